conv_frame_ctrl: RTL and testbench

Frame sequencer for the rate-1/2, 3-flip-flop convolutional encoder (c0 = FF3^FF1, c1 = FF3^FF2^FF1). Buffers one frame of input bits through a valid/ready handshake, clears the encoder, then bursts the frame plus zero tail bits through it at one bit per clock. Emits one coded pair per cycle with valid/last framing. The encoder has no clock enable, so all stalling happens at the input buffer and never at the encoder.

---
 rtl/conv_frame_if.sv | 34 +++
 rtl/conv_frame_ctrl.sv | 156 +++++++++++++++
 tb/tb_conv_frame_ctrl.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_frame_if.sv
// conv_frame_if
//   Groups the bit-stream input handshake and the coded-pair output of
//   conv_frame_ctrl into a single bundle.
//   master : the producer/consumer side (drives in_*, observes out_*)
//   slave  : the frame controller (accepts in_*, drives out_*)
// Signals:
//   in_valid / in_ready : bit transfer handshake (transfer when both high)
//   in_bit              : data bit
//   in_last             : final bit of the frame
//   out_valid           : coded pair valid, no backpressure
//   out_c0 / out_c1     : coded pair
//   out_last            : final pair of the frame
interface conv_frame_if;
  logic in_valid;
  logic in_ready;
  logic in_bit;
  logic in_last;
  logic out_valid;
  logic out_c0;
  logic out_c1;
  logic out_last;

  modport master (
    output in_valid, in_bit, in_last,
    input  in_ready,
    input  out_valid, out_c0, out_c1, out_last
  );

  modport slave (
    input  in_valid, in_bit, in_last,
    output in_ready,
    output out_valid, out_c0, out_c1, out_last
  );
endinterface

// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl
//   Frame sequencer for an external rate-1/2, 3-stage convolutional encoder.
//   Buffers one frame of bits (LOAD), pulses the encoder clear (CLEAR), then
//   streams the frame, optionally followed by three zero tail bits, into the
//   encoder at one bit per clock (SHIFT). Coded pairs are registered and
//   emitted two cycles after the bit is presented; DRAIN lets the last pair
//   leave and marks it with out_last. The encoder cannot stall, so all flow
//   control happens at the input buffer.
//
//   Build option: define CONV_TAIL_FLUSH_EN to append three zero tail bits so
//   the encoder ends every frame in the all-zero state.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   bus        conv_frame_if.slave: input bit handshake and coded-pair output
//   enc_reset  registered active-high encoder clear
//   enc_b0     registered bit presented to the encoder
//   enc_c0/c1  encoder coded outputs
//   busy       high while a frame is being encoded (CLEAR/SHIFT/DRAIN)
//   frame_len  data bits in the current / most recent frame
//   trunc      one-cycle pulse when a frame was cut at MAX_BITS
module conv_frame_ctrl #(
  parameter int MAX_BITS = 64,
  parameter int LEN_W    = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  conv_frame_if.slave      bus,
  output logic             enc_reset,
  output logic             enc_b0,
  input  logic             enc_c0,
  input  logic             enc_c1,
  output logic             busy,
  output logic [LEN_W-1:0] frame_len,
  output logic             trunc
);

  localparam int IDX_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

`ifdef CONV_TAIL_FLUSH_EN
  localparam logic [LEN_W-1:0] TAIL_BITS = LEN_W'(3);
`else
  localparam logic [LEN_W-1:0] TAIL_BITS = LEN_W'(0);
`endif

  typedef enum logic [2:0] {
    S_LOAD,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN1,
    S_DRAIN2
  } state_t;

  state_t             state;
  logic [LEN_W-1:0]   wr_cnt;
  logic [LEN_W-1:0]   sh_cnt;
  logic [MAX_BITS-1:0] frame_buf;
  logic               v1;        // shift strobe delayed one cycle: enc_c* valid

  logic               accept;
  logic               at_limit;
  logic [LEN_W-1:0]   total;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;

  assign bus.in_ready = (state == S_LOAD);
  assign busy         = (state != S_LOAD);
  assign accept       = bus.in_valid && (state == S_LOAD);
  assign at_limit     = (wr_cnt == LEN_W'(MAX_BITS - 1));
  assign total        = frame_len + TAIL_BITS;
  assign wr_idx       = wr_cnt[IDX_W-1:0];
  assign rd_idx       = sh_cnt[IDX_W-1:0];

  // NOTE: the frame buffer is deliberately left out of reset; every location
  // read during SHIFT was written during LOAD of the same frame.
  always_ff @(posedge clk) begin
    if (accept) frame_buf[wr_idx] <= bus.in_bit;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // sees the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_LOAD;
      wr_cnt        <= '0;
      sh_cnt        <= '0;
      frame_len     <= '0;
      enc_reset     <= 1'b1;
      enc_b0        <= 1'b0;
      v1            <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_c0    <= 1'b0;
      bus.out_c1    <= 1'b0;
      bus.out_last  <= 1'b0;
      trunc         <= 1'b0;
    end else begin
      // Output capture pipeline: the pair reflecting bit k is on enc_c* in
      // the cycle after bit k was loaded into enc_b0 (v1 high).
      bus.out_valid <= v1;
      bus.out_c0    <= v1 & enc_c0;
      bus.out_c1    <= v1 & enc_c1;
      bus.out_last  <= 1'b0;
      v1            <= 1'b0;
      trunc         <= 1'b0;
      // enc_b0 rests at 0 outside SHIFT so the first post-clear shift of the
      // encoder pulls in a zero history bit.
      enc_b0        <= 1'b0;

      case (state)
        S_LOAD: begin
          enc_reset <= 1'b0;
          if (accept) begin
            wr_cnt <= wr_cnt + LEN_W'(1);
            if (bus.in_last || at_limit) begin
              frame_len <= wr_cnt + LEN_W'(1);
              wr_cnt    <= '0;
              enc_reset <= 1'b1;
              trunc     <= !bus.in_last;
              state     <= S_CLEAR;
            end
          end
        end

        S_CLEAR: begin
          // Encoder clears at the edge ending this cycle.
          enc_reset <= 1'b0;
          sh_cnt    <= '0;
          state     <= S_SHIFT;
        end

        S_SHIFT: begin
          enc_b0 <= (sh_cnt < frame_len) ? frame_buf[rd_idx] : 1'b0;
          sh_cnt <= sh_cnt + LEN_W'(1);
          v1     <= 1'b1;
          if (sh_cnt == total - LEN_W'(1)) state <= S_DRAIN1;
        end

        S_DRAIN1: begin
          // Last pair is captured at the end of this cycle.
          bus.out_last <= 1'b1;
          state        <= S_DRAIN2;
        end

        S_DRAIN2: begin
          state <= S_LOAD;
        end

        default: begin
          state <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// tb_conv_frame_ctrl
//   Self-checking bench for conv_frame_ctrl. Contains a cycle model of the
//   external 3-stage encoder, drives randomized frames through the input
//   handshake and compares every coded pair against a sequence-level
//   convolution of the frame bits.
module tb_conv_frame_ctrl;
  localparam int MAX_BITS = 64;
  localparam int LEN_W    = 7;
  localparam int LOGN     = 8192;
`ifdef CONV_TAIL_FLUSH_EN
  localparam int TAIL = 3;
`else
  localparam int TAIL = 0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enc_reset;
  logic             enc_b0;
  logic             enc_c0;
  logic             enc_c1;
  logic             busy;
  logic             trunc;
  logic [LEN_W-1:0] frame_len;

  conv_frame_if bus ();

  conv_frame_ctrl #(.MAX_BITS(MAX_BITS), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .enc_reset (enc_reset),
    .enc_b0    (enc_b0),
    .enc_c0    (enc_c0),
    .enc_c1    (enc_c1),
    .busy      (busy),
    .frame_len (frame_len),
    .trunc     (trunc)
  );

  always #5 clk = ~clk;

  // External encoder: the current input and the two previous inputs.
  logic s1, s2;
  always @(posedge clk) begin
    if (enc_reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= enc_b0;
      s2 <= s1;
    end
  end
  assign enc_c0 = enc_b0 ^ s2;
  assign enc_c1 = enc_b0 ^ s1 ^ s2;

  typedef struct {
    bit c0;
    bit c1;
    bit last;
    int cyc;
  } pair_t;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    stray_last = 0;
  pair_t mon_q[$];
  pair_t mp;
  bit    ready_log [LOGN];
  bit    busy_log  [LOGN];
  bit    enc_log   [LOGN];
  bit    trunc_log [LOGN];
  bit    tx_bits   [0:127];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      ready_log[cyc] = bus.in_ready;
      busy_log[cyc]  = busy;
      enc_log[cyc]   = enc_reset;
      trunc_log[cyc] = trunc;
    end
    if (bus.out_valid === 1'b1) begin
      mp.c0   = bus.out_c0;
      mp.c1   = bus.out_c1;
      mp.last = bus.out_last;
      mp.cyc  = cyc;
      mon_q.push_back(mp);
    end else if (bus.out_last === 1'b1) begin
      stray_last++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // Reference: bit k of the frame, with zeros outside the frame (history
  // before the clear and tail bits after it).
  function automatic bit exp_bit(input int base, input int n, input int k);
    if (k < 0 || k >= n) return 1'b0;
    return tx_bits[base + k];
  endfunction

  task automatic send_frame(input int base, input int n, input int gap_pct,
                            input bit with_last, input int max_stall,
                            output int t_end, output int accepted);
    int i;
    int stall;
    int guard;
    i = 0; stall = 0; guard = 0; t_end = -1; accepted = 0;
    while (i < n && stall < max_stall && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_bit   = tx_bits[base + i];
        bus.in_last  = with_last && (i == n - 1);
        if (bus.in_ready) begin
          accepted++;
          t_end = cyc;
          i++;
          stall = 0;
        end else begin
          stall++;
        end
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_bit   = 1'b0;
  endtask

  task automatic wait_idle(input int t_end, input int n);
    int guard;
    guard = 0;
    while (cyc < t_end + n + TAIL + 8 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic check_frame(input string name, input int base, input int n,
                             input int t_end);
    int    total;
    int    bad_data;
    int    bad_time;
    int    bad_last;
    bit    e0;
    bit    e1;
    pair_t p;
    total = n + TAIL;
    bad_data = 0; bad_time = 0; bad_last = 0;
    checks++;
    if (t_end < 0 || mon_q.size() < total) begin
      errors++;
      $display("FAIL %s pair_count: got %0d pairs, expected %0d (t_end=%0d)",
               name, mon_q.size(), total, t_end);
      mon_q.delete();
      return;
    end
    for (int k = 0; k < total; k++) begin
      e0 = exp_bit(base, n, k) ^ exp_bit(base, n, k - 2);
      e1 = exp_bit(base, n, k) ^ exp_bit(base, n, k - 1) ^ exp_bit(base, n, k - 2);
      p = mon_q.pop_front();
      if (p.c0 !== e0 || p.c1 !== e1) begin
        if (bad_data == 0)
          $display("FAIL %s pair_data: pair %0d got (%0d,%0d) expected (%0d,%0d)",
                   name, k, p.c0, p.c1, e0, e1);
        bad_data++;
      end
      if (p.cyc != t_end + 4 + k) begin
        if (bad_time == 0)
          $display("FAIL %s pair_timing: pair %0d at cycle %0d expected %0d",
                   name, k, p.cyc, t_end + 4 + k);
        bad_time++;
      end
      if (p.last !== (k == total - 1)) begin
        if (bad_last == 0)
          $display("FAIL %s out_last: pair %0d got %0d expected %0d",
                   name, k, p.last, (k == total - 1));
        bad_last++;
      end
    end
    if (bad_data != 0) errors++;
    checks++;
    if (bad_time != 0) errors++;
    checks++;
    if (bad_last != 0) errors++;
  endtask

  task automatic test_reset;
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    bus.in_last  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (enc_reset !== 1'b1 || enc_b0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_enc: got enc_reset=%0d enc_b0=%0d expected 1,0", enc_reset, enc_b0);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_c0 !== 1'b0 || bus.out_c1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got valid=%0d last=%0d c0=%0d c1=%0d expected all 0",
               bus.out_valid, bus.out_last, bus.out_c0, bus.out_c1);
    end
    checks++;
    if (busy !== 1'b0 || trunc !== 1'b0 || frame_len !== '0) begin
      errors++;
      $display("FAIL reset_status: got busy=%0d trunc=%0d frame_len=%0d expected 0,0,0",
               busy, trunc, frame_len);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got in_ready=%0d expected 1", bus.in_ready);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (enc_reset !== 1'b0) begin
      errors++;
      $display("FAIL load_enc_reset: got %0d expected 0", enc_reset);
    end
  endtask

  task automatic test_single_bit;
    int t;
    int acc;
    int tot;
    mon_q.delete();
    tx_bits[0] = 1'b1;
    send_frame(0, 1, 0, 1'b1, 8, t, acc);
    wait_idle(t, 1);
    tot = 1 + TAIL;
    checks++;
    if (enc_log[t] !== 1'b0 || enc_log[t + 1] !== 1'b1 || enc_log[t + 2] !== 1'b0) begin
      errors++;
      $display("FAIL single_enc_reset: got %0d%0d%0d around handshake, expected 010",
               enc_log[t], enc_log[t + 1], enc_log[t + 2]);
    end
    checks++;
    if (busy_log[t + 1] !== 1'b1 || busy_log[t + 3 + tot] !== 1'b1 || busy_log[t + 4 + tot] !== 1'b0) begin
      errors++;
      $display("FAIL single_busy: got %0d,%0d,%0d expected 1,1,0",
               busy_log[t + 1], busy_log[t + 3 + tot], busy_log[t + 4 + tot]);
    end
    check_frame("single", 0, 1, t);
    checks++;
    if (frame_len !== LEN_W'(1)) begin
      errors++;
      $display("FAIL single_frame_len: got %0d expected 1", frame_len);
    end
  endtask

  task automatic test_gapped;
    int t;
    int acc;
    logic [1:0] table_exp [4];
    table_exp[0] = 2'b11; table_exp[1] = 2'b01; table_exp[2] = 2'b00; table_exp[3] = 2'b10;
    mon_q.delete();
    tx_bits[0] = 1; tx_bits[1] = 0; tx_bits[2] = 1; tx_bits[3] = 1;
    send_frame(0, 4, 40, 1'b1, 8, t, acc);
    wait_idle(t, 4);
    checks++;
    if (mon_q.size() < 4) begin
      errors++;
      $display("FAIL gapped_table: got %0d pairs expected at least 4", mon_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        if ({mon_q[k].c0, mon_q[k].c1} !== table_exp[k]) begin
          errors++;
          $display("FAIL gapped_table: pair %0d got %b expected %b",
                   k, {mon_q[k].c0, mon_q[k].c1}, table_exp[k]);
          break;
        end
      end
    end
    check_frame("gapped", 0, 4, t);
    checks++;
    if (frame_len !== LEN_W'(4)) begin
      errors++;
      $display("FAIL gapped_frame_len: got %0d expected 4", frame_len);
    end
  endtask

  task automatic test_truncate;
    int t;
    int acc;
    int pulses;
    mon_q.delete();
    for (int i = 0; i < 70; i++) tx_bits[i] = 1'($urandom);
    send_frame(0, 70, 0, 1'b0, 4, t, acc);
    wait_idle(t, MAX_BITS);
    checks++;
    if (acc != MAX_BITS) begin
      errors++;
      $display("FAIL trunc_accepted: got %0d bits expected %0d", acc, MAX_BITS);
    end
    pulses = 0;
    for (int c = t - MAX_BITS; c < t + MAX_BITS + TAIL + 6; c++)
      if (c >= 0 && trunc_log[c]) pulses++;
    checks++;
    if (trunc_log[t + 1] !== 1'b1 || pulses != 1 || ready_log[t + 1] !== 1'b0) begin
      errors++;
      $display("FAIL trunc_pulse: got trunc@t+1=%0d pulses=%0d ready@t+1=%0d expected 1,1,0",
               trunc_log[t + 1], pulses, ready_log[t + 1]);
    end
    check_frame("trunc", 0, MAX_BITS, t);
    checks++;
    if (frame_len !== LEN_W'(MAX_BITS)) begin
      errors++;
      $display("FAIL trunc_frame_len: got %0d expected %0d", frame_len, MAX_BITS);
    end
  endtask

  task automatic test_exact_max;
    int t;
    int acc;
    int pulses;
    mon_q.delete();
    for (int i = 0; i < MAX_BITS; i++) tx_bits[i] = 1'($urandom);
    send_frame(0, MAX_BITS, 10, 1'b1, 8, t, acc);
    wait_idle(t, MAX_BITS);
    pulses = 0;
    for (int c = t - MAX_BITS; c < t + MAX_BITS + TAIL + 6; c++)
      if (c >= 0 && trunc_log[c]) pulses++;
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL exact_no_trunc: got %0d trunc pulses expected 0", pulses);
    end
    check_frame("exact", 0, MAX_BITS, t);
    checks++;
    if (frame_len !== LEN_W'(MAX_BITS)) begin
      errors++;
      $display("FAIL exact_frame_len: got %0d expected %0d", frame_len, MAX_BITS);
    end
  endtask

  task automatic test_mid_reset;
    int t;
    int acc;
    int guard;
    int lasts;
    mon_q.delete();
    stray_last = 0;
    tx_bits[0] = 1; tx_bits[1] = 0; tx_bits[2] = 1; tx_bits[3] = 1;
    send_frame(0, 4, 0, 1'b1, 8, t, acc);
    guard = 0;
    while (cyc < t + 5 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || enc_reset !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_state: got valid=%0d enc_reset=%0d busy=%0d ready=%0d expected 0,1,0,1",
               bus.out_valid, enc_reset, busy, bus.in_ready);
    end
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    lasts = stray_last;
    foreach (mon_q[k]) if (mon_q[k].last) lasts++;
    checks++;
    if (lasts != 0) begin
      errors++;
      $display("FAIL midreset_no_last: got %0d out_last assertions expected 0", lasts);
    end
    mon_q.delete();
    tx_bits[0] = 1'b1;
    send_frame(0, 1, 0, 1'b1, 8, t, acc);
    wait_idle(t, 1);
    check_frame("after_reset", 0, 1, t);
  endtask

  task automatic test_back_to_back;
    int t1;
    int t2;
    int acc;
    int tot1;
    bit ready_ok;
    mon_q.delete();
    tx_bits[0] = 1;
    tx_bits[1] = 1; tx_bits[2] = 0; tx_bits[3] = 1; tx_bits[4] = 1;
    send_frame(0, 1, 0, 1'b1, 8, t1, acc);
    send_frame(1, 4, 0, 1'b1, 200, t2, acc);
    wait_idle(t2, 4);
    tot1 = 1 + TAIL;
    ready_ok = 1'b1;
    for (int c = t1 + 1; c <= t1 + 3 + tot1; c++) if (ready_log[c] !== 1'b0) ready_ok = 1'b0;
    if (ready_log[t1 + 4 + tot1] !== 1'b1) ready_ok = 1'b0;
    checks++;
    if (!ready_ok) begin
      errors++;
      $display("FAIL b2b_in_ready: in_ready not low over cycles %0d..%0d then high at %0d",
               t1 + 1, t1 + 3 + tot1, t1 + 4 + tot1);
    end
    check_frame("b2b_first", 0, 1, t1);
    check_frame("b2b_second", 1, 4, t2);
    checks++;
    if (frame_len !== LEN_W'(4)) begin
      errors++;
      $display("FAIL b2b_frame_len: got %0d expected 4", frame_len);
    end
  endtask

  task automatic test_random;
    int t;
    int acc;
    int n;
    for (int f = 0; f < 6; f++) begin
      mon_q.delete();
      n = $urandom_range(MAX_BITS, 1);
      for (int i = 0; i < n; i++) tx_bits[i] = 1'($urandom);
      send_frame(0, n, $urandom_range(50), 1'b1, 8, t, acc);
      wait_idle(t, n);
      check_frame("random", 0, n, t);
      checks++;
      if (frame_len !== LEN_W'(n)) begin
        errors++;
        $display("FAIL random_frame_len: got %0d expected %0d", frame_len, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_gapped();
    test_truncate();
    test_exact_max();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
